// File: rtl/tdc_readout_pkg.sv
// Shared types and default constants for the TDC readout sequencer.
package tdc_readout_pkg;

  localparam int unsigned TDC_CODE_W     = 8;
  localparam int unsigned TDC_ACC_W      = 20;
  localparam int unsigned TDC_SETTLE_CYC = 4;
  localparam int unsigned TDC_NUM_TERMS  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLaunch,
    StSettle,
    StCapture,
    StDone
  } tdc_state_e;

  // $clog2 returns 0 for a count of 1; every counter needs at least one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdc_sat_acc.sv
// Saturating accumulator register with synchronous clear and a sticky overflow flag.
module tdc_sat_acc #(
  parameter int unsigned CODE_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [CODE_W-1:0] code,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] AccMax = '1;

  logic [ACC_W:0] sum;

  assign sum = {1'b0, acc} + (ACC_W + 1)'(code);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      // Once saturated the result is pinned at full scale until the next clear.
      if (ovf || sum[ACC_W]) begin
        acc <= AccMax;
        ovf <= 1'b1;
      end else begin
        acc <= sum[ACC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tdc_readout_seq.sv
// TDC conversion sequencer: clear, launch, settle, capture per term; sums codes into
// a saturating result presented on a valid/ready port.
module tdc_readout_seq
  import tdc_readout_pkg::*;
#(
  parameter int unsigned CODE_W     = TDC_CODE_W,
  parameter int unsigned ACC_W      = TDC_ACC_W,
  parameter int unsigned SETTLE_CYC = TDC_SETTLE_CYC,
  parameter int unsigned NUM_TERMS  = TDC_NUM_TERMS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CODE_W-1:0] code_i,
  output logic              tdc_rst_n,
  output logic              conv_go,
  output logic              busy,
  output logic [ACC_W-1:0]  acc_o,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf
);

  localparam int unsigned SW = cnt_w(SETTLE_CYC);
  localparam int unsigned TW = cnt_w(NUM_TERMS);
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TermLast   = TW'(NUM_TERMS - 1);

  tdc_state_e    state_q;
  logic [SW-1:0] settle_q;
  logic [TW-1:0] term_q;
  logic          acc_clr;
  logic          acc_en;

  assign acc_clr = (state_q == StIdle) && start;
  assign acc_en  = (state_q == StCapture);

  // Outputs are loaded on the transition into the state that owns them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      term_q    <= '0;
      tdc_rst_n <= 1'b1;
      conv_go   <= 1'b0;
      busy      <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StClear;
            term_q    <= '0;
            tdc_rst_n <= 1'b0;
            busy      <= 1'b1;
          end
        end
        StClear: begin
          state_q   <= StLaunch;
          tdc_rst_n <= 1'b1;
          conv_go   <= 1'b1;
        end
        StLaunch: begin
          state_q  <= StSettle;
          conv_go  <= 1'b0;
          settle_q <= '0;
        end
        StSettle: begin
          if (settle_q == SettleLast) begin
            state_q <= StCapture;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StCapture: begin
          if (term_q == TermLast) begin
            state_q   <= StDone;
            acc_valid <= 1'b1;
          end else begin
            state_q   <= StClear;
            term_q    <= term_q + 1'b1;
            tdc_rst_n <= 1'b0;
          end
        end
        StDone: begin
          if (acc_ready) begin
            state_q   <= StIdle;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  tdc_sat_acc #(
    .CODE_W (CODE_W),
    .ACC_W  (ACC_W)
  ) u_sat_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .en   (acc_en),
    .code (code_i),
    .acc  (acc_o),
    .ovf  (ovf)
  );

endmodule

// File: tb/tb_tdc_readout_seq.sv
// Directed bench for tdc_readout_seq: default-parameter instance plus a narrow
// accumulator instance for saturation.
module tb_tdc_readout_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  code_i = 8'h00;
  logic        acc_ready = 1'b1;
  logic        tdc_rst_n, conv_go, busy, acc_valid, ovf;
  logic [19:0] acc_o;

  logic        s_start = 1'b0;
  logic [7:0]  s_code = 8'h00;
  logic        s_ready = 1'b1;
  logic        s_tdc_rst_n, s_conv_go, s_busy, s_acc_valid, s_ovf;
  logic [9:0]  s_acc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tdc_readout_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .code_i    (code_i),
    .tdc_rst_n (tdc_rst_n),
    .conv_go   (conv_go),
    .busy      (busy),
    .acc_o     (acc_o),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .ovf       (ovf)
  );

  tdc_readout_seq #(
    .ACC_W (10)
  ) dut_s (
    .clk       (clk),
    .rst       (rst),
    .start     (s_start),
    .code_i    (s_code),
    .tdc_rst_n (s_tdc_rst_n),
    .conv_go   (s_conv_go),
    .busy      (s_busy),
    .acc_o     (s_acc),
    .acc_valid (s_acc_valid),
    .acc_ready (s_ready),
    .ovf       (s_ovf)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ":tdc_rst_n"}, int'(tdc_rst_n), 1);
    check({tag, ":conv_go"}, int'(conv_go), 0);
    check({tag, ":busy"}, int'(busy), 0);
    check({tag, ":acc_valid"}, int'(acc_valid), 0);
    check({tag, ":acc_o"}, int'(acc_o), 0);
    check({tag, ":ovf"}, int'(ovf), 0);
  endtask

  // Checks cycles 1..last of a default-parameter result (P=7, 16 terms); returns
  // sampling cycle last+1. Extra start pulses land in cycles 50 and 113.
  task automatic run_dflt(input logic [7:0] code, input int last, input bit extra,
                          input bit do_start);
    int ph;
    int e_acc;
    code_i = code;
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int cyc = 1; cyc <= last; cyc++) begin
      ph    = (cyc - 1) % 7;
      e_acc = int'(code) * ((cyc - 1) / 7);
      check($sformatf("tdc_rst_n@%0d", cyc), int'(tdc_rst_n), (cyc <= 112 && ph == 0) ? 0 : 1);
      check($sformatf("conv_go@%0d", cyc), int'(conv_go), (cyc <= 112 && ph == 1) ? 1 : 0);
      check($sformatf("busy@%0d", cyc), int'(busy), 1);
      check($sformatf("acc_valid@%0d", cyc), int'(acc_valid), (cyc == 113) ? 1 : 0);
      check($sformatf("acc_o@%0d", cyc), int'(acc_o), e_acc);
      check($sformatf("ovf@%0d", cyc), int'(ovf), 0);
      start = extra && (cyc == 50 || cyc == 113);
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    // Reset held with the clock running.
    repeat (2) step();
    check_reset_vals("por");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle_busy%0d", i), int'(busy), 0);
      check($sformatf("idle_rst_n%0d", i), int'(tdc_rst_n), 1);
    end

    // Default run with ignored start pulses at 50 and 113.
    acc_ready = 1'b1;
    run_dflt(8'h05, 113, 1'b1, 1'b1);
    for (int cyc = 114; cyc <= 116; cyc++) begin
      check($sformatf("post_busy@%0d", cyc), int'(busy), 0);
      check($sformatf("post_valid@%0d", cyc), int'(acc_valid), 0);
      check($sformatf("post_rst_n@%0d", cyc), int'(tdc_rst_n), 1);
      step();
    end

    // Backpressure: result held while acc_ready is low.
    acc_ready = 1'b0;
    run_dflt(8'h05, 113, 1'b0, 1'b1);
    for (int cyc = 114; cyc <= 122; cyc++) begin
      check($sformatf("bp_valid@%0d", cyc), int'(acc_valid), 1);
      check($sformatf("bp_acc@%0d", cyc), int'(acc_o), 80);
      step();
    end
    acc_ready = 1'b1;
    check("bp_valid@123", int'(acc_valid), 1);
    step();
    check("bp_valid_drop", int'(acc_valid), 0);
    check("bp_busy_drop", int'(busy), 0);
    check("bp_acc_hold", int'(acc_o), 80);
    start = 1'b1;
    step();
    start = 1'b0;
    // Start in the post-handshake cycle was taken: this is cycle 1 of a new result.
    run_dflt(8'h05, 39, 1'b0, 1'b0);

    // Asynchronous reset mid-run, in the middle of cycle 40.
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    step();
    rst = 1'b1;
    step();
    check("midrst_idle_busy", int'(busy), 0);
    step();
    check("midrst_idle_go", int'(conv_go), 0);
    run_dflt(8'h01, 113, 1'b0, 1'b1);

    // Saturation on the 10-bit accumulator.
    s_code  = 8'hFF;
    s_ready = 1'b1;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int cyc = 1; cyc <= 113; cyc++) begin
      if (cyc == 29) begin
        check("sat_acc@29", int'(s_acc), 1020);
        check("sat_ovf@29", int'(s_ovf), 0);
      end
      if (cyc == 36) begin
        check("sat_acc@36", int'(s_acc), 1023);
        check("sat_ovf@36", int'(s_ovf), 1);
      end
      if (cyc == 113) begin
        check("sat_valid@113", int'(s_acc_valid), 1);
        check("sat_acc@113", int'(s_acc), 1023);
        check("sat_ovf@113", int'(s_ovf), 1);
      end
      step();
    end
    check("sat_valid@114", int'(s_acc_valid), 0);
    check("sat_ovf_sticky", int'(s_ovf), 1);
    check("sat_acc_sticky", int'(s_acc), 1023);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    check("sat_restart_acc", int'(s_acc), 0);
    check("sat_restart_ovf", int'(s_ovf), 0);
    check("sat_restart_busy", int'(s_busy), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
